// File: rtl/sd_cic_decimator.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sd_cic_decimator
//
// Sinc3 (third-order CIC) decimator. It turns the 1-bit sigma-delta bitstream
// into signed PCM samples at 1/OSR of the accepted bit rate, with
// OSR = 2**LOG2_OSR.
//
// Structure:
//   - Three integrators running at the bit rate, updated only on accepted bits.
//   - Decimation counter. It produces one tick per OSR accepted bits.
//   - Three comb stages that form a fixed pipeline. They advance one stage per
//     clock after each tick.
//   - Scaling to OUT_W bits with positive saturation, then a registered output.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears every register
//   bit_in       modulator bit (1 -> +1, 0 -> -1)
//   bit_valid    qualifies bit_in; integrators and counter hold while low
//   sample_out   decimated signed sample; holds its value between strobes
//   sample_valid one-cycle strobe marking a new sample_out
//   sample_sat   high with sample_valid when sample_out was clamped
// ----------------------------------------------------------------------------
module sd_cic_decimator #(
  parameter int LOG2_OSR = 6,
  parameter int OUT_W    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    sample_sat
);

  // The CIC gain is OSR**3, so it needs 3*LOG2_OSR bits.
  // Two more bits cover the sign and the +OSR**3 full-scale value.
  localparam int ACC_W = 3 * LOG2_OSR + 2;
  localparam int SHIFT = OUT_W - 1 - 3 * LOG2_OSR;
  localparam int Y_W   = ACC_W + SHIFT;

  localparam logic        [LOG2_OSR-1:0] CNT_LAST = '1;
  localparam logic signed [ACC_W-1:0]    ACC_ONE  = ACC_W'(1);
  localparam logic signed [OUT_W-1:0]    OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] i1, i2, i3;
  logic        [LOG2_OSR-1:0] cnt;
  logic                    tick;

  logic signed [ACC_W-1:0] d0, d0_z;
  logic signed [ACC_W-1:0] c1, c1_z;
  logic signed [ACC_W-1:0] c2, c2_z;
  logic signed [ACC_W-1:0] c3;
  logic                    v0, v1, v2;

  logic signed [Y_W-1:0]   y;
  logic                    pos_over;

  // Map the bit onto +1 / -1 at the accumulator width.
  assign x = bit_in ? ACC_ONE : '1;

  // The last bit of each OSR-bit frame starts a new output sample.
  assign tick = bit_valid && (cnt == CNT_LAST);

  // Integrator chain and decimation counter. Each stage adds the pre-edge
  // value of the stage before it. Overflow wraps modulo 2**ACC_W by design,
  // and the comb differences undo that wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      cnt <= '0;
    end else if (bit_valid) begin
      i1  <= i1 + x;
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      cnt <= cnt + 1'b1;
    end
  end

  // Decimated sample capture. i3 + i2 equals the value i3 takes at this
  // same edge, so the comb sees the integrator state after the tick bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0 <= '0;
      v0 <= 1'b0;
    end else begin
      v0 <= tick;
      if (tick) begin
        d0 <= i3 + i2;
      end
    end
  end

  // First two comb stages. Each stage runs once per sample, on the clock
  // after the previous stage. The stage-valid flags carry the sample along
  // whatever bit_valid does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1   <= '0;
      c1_z <= '0;
      c2   <= '0;
      d0_z <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
    end else begin
      v1 <= v0;
      v2 <= v1;
      if (v0) begin
        c1   <= d0 - d0_z;
        d0_z <= d0;
      end
      if (v1) begin
        c2   <= c2_diff(c1, c1_z);
        c1_z <= c1;
      end
    end
  end

  function automatic logic signed [ACC_W-1:0] c2_diff(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    return a - b;
  endfunction

  // The third comb stage feeds the output register directly.
  assign c3 = c2 - c2_z;

  // Scale c3 to full scale at OUT_W bits. Legal c3 lies in [-OSR**3, +OSR**3].
  // So y can only leave the output range at the top, by exactly one LSB.
  // The bottom value, -2**(OUT_W-1), is representable as it stands.
  assign y        = Y_W'(c3) <<< SHIFT;
  assign pos_over = !y[Y_W-1] && y[Y_W-2];

  // Output register. sample_out keeps the last sample.
  // sample_sat is meaningful only together with the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c2_z         <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sample_sat   <= 1'b0;
    end else begin
      sample_valid <= v2;
      sample_sat   <= v2 && pos_over;
      if (v2) begin
        c2_z       <= c2;
        sample_out <= pos_over ? OUT_MAX : y[OUT_W-1:0];
      end
    end
  end

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
Sinc3 (3rd-order CIC) decimation filter that converts the 1-bit sigma-delta bitstream from the modulator into signed multi-bit PCM samples at 1/OSR of the bit rate. It sits directly after the sigma-delta modulator on the receive side. It accepts one bit per qualified cycle and emits one scaled, saturated sample per OSR accepted bits with a one-cycle valid strobe.

Parameters:
LOG2_OSR, 6, log2 of the decimation ratio; OSR = 2**LOG2_OSR; legal range 2..7.
OUT_W, 24, output sample width, signed two's complement; must satisfy OUT_W-1 >= 3*LOG2_OSR.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
bit_in  input  1  modulator bitstream; 1 = +1, 0 = -1
bit_valid  input  1  qualifies bit_in this cycle; all state holds when low
sample_out  output  OUT_W  decimated signed sample, scaled and saturated
sample_valid  output  1  one-cycle strobe; sample_out is valid in that cycle
sample_sat  output  1  high with sample_valid when sample_out was clamped

Behaviour:
- Reset (async, active-high): all integrators, comb delays, pipeline registers and the decimation counter are set to 0. Outputs are sample_out=0, sample_valid=0, sample_sat=0.
- Internal width is ACC_W = 3*LOG2_OSR + 2; 20 bits at default.
- Input mapping: x = +1 when bit_in=1, x = -1 when bit_in=0, sign-extended to ACC_W.
- Integrators update only on an edge with bit_valid=1. Each stage uses pre-edge values: i1<=i1+x, i2<=i2+i1, i3<=i3+i2.
- All integrator and comb arithmetic is modulo 2^ACC_W. Wrap-around is intentional and must not be detected or saturated.
- Decimation counter, LOG2_OSR bits, increments on each accepted bit and wraps from OSR-1 to 0.
- Tick: an accepted bit while the counter equals OSR-1. On the tick edge, d0 <= i3+i2 (i.e. the post-edge i3).
- Comb pipeline runs one stage per clock, unconditionally, regardless of bit_valid:
  - E1: c1 = d0 - d0_z, then d0_z <= d0
  - E2: c2 = c1 - c1_z, then c1_z <= c1
  - E3: c3 = c2 - c2_z, then c2_z <= c2; output register loads at this edge.
- Latency: sample_valid is high for exactly the one cycle following edge E3, i.e. 3 clocks after the tick edge. A new tick cannot arrive inside the pipeline window because OSR >= 4.
- Scaling: y = c3 arithmetically shifted left by (OUT_W-1-3*LOG2_OSR). The full-scale range is ±2^(OUT_W-1).
- Saturation: y > 2^(OUT_W-1)-1 is clamped to the maximum positive value and sets sample_sat=1. -2^(OUT_W-1) is representable and is not flagged.
- sample_out holds its last value between strobes. sample_sat is valid only when sample_valid=1 and is 0 otherwise.
- Settling: the first 3 samples after reset are transient. For periodic input whose period divides OSR, the 4th and later samples are exact.
- bit_valid gaps of any length, at any counter value, do not alter results. The sample sequence depends only on the sequence of accepted bits.
- Reset mid-operation (including mid-pipeline): any in-flight sample is discarded and no strobe is produced. The next strobe comes 3 clocks after the OSR-th bit accepted after reset release.

Test Plan:
- All ones, bit_valid=1 continuous, defaults: sample_valid every 64 cycles. Outputs 4 onward are 0x7FFFFF with sample_sat=1.
- All zeros: outputs 4 onward are 0x800000 with sample_sat=0.
- Alternating 1,0,1,0: outputs 4 onward are 0x000000. Repeating 1,1,1,0: outputs 4 onward are 0x400000, sat=0.
- Same 1,1,1,0 stream with bit_valid randomly deasserted (~50%): the output sequence is identical to the gap-free run. The strobe fires exactly 3 clocks after every 64th accepted bit.
- Reset asserted 1 cycle after a tick edge: no strobe follows, and all outputs read 0 during reset. After release, the first strobe appears 3 clocks after the 64th accepted bit.
- LOG2_OSR=2, OUT_W=8, all ones: strobe every 4 accepted bits. Outputs 4 onward are 0x7F with sat=1. All zeros gives 0x80.
